// File: rtl/pool_frame_buffer.sv
// pool_frame_buffer
//   Frame buffer between the six layer-1 conv+pool channels and the layer-2
//   convolution front end. It captures one frame of NCH pooled maps that
//   arrive in parallel (one word per channel per beat), then replays the
//   frame channel-major over a valid/ready handshake. Capture and replay
//   take turns on one buffer and never overlap.
//
//   Optional build macro: POOL_FRAME_BUFFER_RELU_EN. When it is defined,
//   negative words are stored as 0. Control timing is the same in both builds.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous reset, active low
//   pool_in      packed pooled pixels; channel c at [c*(OP+1) +: OP+1]
//   pool_valid   per-channel valid; a beat is a cycle with all bits set
//   out_pxl      replayed pixel (signed)
//   out_ch       channel index of out_pxl
//   out_valid    out_pxl/out_ch valid
//   out_ready    downstream accepts when out_valid && out_ready
//   frame_done   one-cycle pulse after the last replayed word is accepted
//   busy         high while replaying (DRAIN)
//   err_skew     sticky: pool_valid bits disagreed in some cycle
//   err_overrun  sticky: a beat arrived while replaying
//
// state   | meaning
// S_FILL  | capturing beats into the buffer
// S_DRAIN | replaying the captured frame, input beats are dropped
module pool_frame_buffer #(
  parameter int OP    = 8,
  parameter int NCH   = 6,
  parameter int MAP_W = 14,
  parameter int MAP_H = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*(OP+1)-1:0]  pool_in,
  input  logic [NCH-1:0]         pool_valid,
  output logic [OP:0]            out_pxl,
  output logic [2:0]             out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   err_skew,
  output logic                   err_overrun
);

  localparam int W     = OP + 1;
  localparam int MAP_N = MAP_W * MAP_H;
  localparam int TOTAL = NCH * MAP_N;
  localparam int IW    = $clog2(MAP_N);
  localparam int AW    = $clog2(TOTAL);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t state, next_state;

  logic [IW-1:0] wcnt;
  logic [IW-1:0] rd_idx;
  logic [2:0]    rd_ch;
  logic          rd_done;
  logic          rd_vld;
  logic [2:0]    rd_ch_q;
  logic [AW-1:0] acc_cnt;
  logic          sk_vld;
  logic [W-1:0]  sk_pxl;
  logic [2:0]    sk_ch;
  logic [W-1:0]  rdata;
  logic [NCH-1:0][W-1:0] bank_q;

  logic beat, skew, fill_beat, last_wr, pop, last_pop, issue;
  logic [1:0] occ, occ_after;

  assign beat      = &pool_valid;
  assign skew      = (|pool_valid) && !beat;
  assign fill_beat = (state == S_FILL) && beat;
  assign last_wr   = (wcnt == IW'(MAP_N - 1));
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (acc_cnt == AW'(TOTAL - 1));
  assign busy      = (state == S_DRAIN);

  // Words in flight plus words buffered never exceed the two output slots.
  // Address 0 is read during the final capture beat so the first output word
  // appears one cycle after DRAIN is entered.
  assign occ       = 2'(out_valid) + 2'(sk_vld) + 2'(rd_vld);
  assign occ_after = occ - 2'(pop);
  assign issue     = (fill_beat && last_wr) ||
                     ((state == S_DRAIN) && !rd_done && (occ_after < 2'd2));

  always_comb begin
    next_state = state;
    case (state)
      S_FILL:  if (fill_beat && last_wr) next_state = S_DRAIN;
      S_DRAIN: if (last_pop)             next_state = S_FILL;
      default: next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FILL;
    else        state <= next_state;
  end

  // One bank per channel so all NCH words of a beat are written together;
  // replay address ch*MAP_N + idx maps to bank ch, entry idx.
  for (genvar c = 0; c < NCH; c++) begin : g_bank
    logic [W-1:0] mem [MAP_N];
    logic [W-1:0] raw, din, q;
    assign raw = pool_in[c*W +: W];
`ifdef POOL_FRAME_BUFFER_RELU_EN
    assign din = raw[W-1] ? '0 : raw;
`else
    assign din = raw;
`endif
    always_ff @(posedge clk) begin
      if (fill_beat) mem[wcnt] <= din;
      if (issue)     q <= mem[rd_idx];
    end
    assign bank_q[c] = q;
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++)
      if (rd_ch_q == 3'(c)) rdata = bank_q[c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt        <= '0;
      rd_idx      <= '0;
      rd_ch       <= '0;
      rd_done     <= 1'b0;
      rd_vld      <= 1'b0;
      rd_ch_q     <= '0;
      acc_cnt     <= '0;
      frame_done  <= 1'b0;
      err_skew    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      frame_done <= last_pop;
      if (skew) err_skew <= 1'b1;
      if (beat && state == S_DRAIN) err_overrun <= 1'b1;
      if (fill_beat) wcnt <= last_wr ? '0 : wcnt + 1'b1;

      rd_vld <= issue;
      if (issue) begin
        rd_ch_q <= rd_ch;
        if (rd_idx == IW'(MAP_N - 1)) begin
          rd_idx <= '0;
          if (rd_ch == 3'(NCH - 1)) begin
            rd_ch   <= '0;
            rd_done <= 1'b1;
          end else begin
            rd_ch <= rd_ch + 1'b1;
          end
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end

      if (pop) acc_cnt <= last_pop ? '0 : acc_cnt + 1'b1;
      if (last_pop) rd_done <= 1'b0;
    end
  end

  // Two-slot output: head register drives the port, skid catches the word
  // that was already in flight when the head stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pxl   <= '0;
      out_ch    <= '0;
      sk_vld    <= 1'b0;
      sk_pxl    <= '0;
      sk_ch     <= '0;
    end else if (pop || !out_valid) begin
      if (sk_vld) begin
        out_valid <= 1'b1;
        out_pxl   <= sk_pxl;
        out_ch    <= sk_ch;
        sk_vld    <= rd_vld;
        if (rd_vld) begin
          sk_pxl <= rdata;
          sk_ch  <= rd_ch_q;
        end
      end else begin
        out_valid <= rd_vld;
        if (rd_vld) begin
          out_pxl <= rdata;
          out_ch  <= rd_ch_q;
        end
      end
    end else if (rd_vld) begin
      sk_vld <= 1'b1;
      sk_pxl <= rdata;
      sk_ch  <= rd_ch_q;
    end
  end

endmodule

// File: tb/tb_pool_frame_buffer.sv
module tb_pool_frame_buffer;
  localparam int NCH   = 6;
  localparam int MAP_N = 196;
  localparam int TOTAL = 1176;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*9-1:0]  pool_in;
  logic [NCH-1:0]    pool_valid;
  logic [8:0]        out_pxl;
  logic [2:0]        out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              frame_done;
  logic              busy;
  logic              err_skew;
  logic              err_overrun;

  pool_frame_buffer dut (
    .clk(clk), .reset(reset), .pool_in(pool_in), .pool_valid(pool_valid),
    .out_pxl(out_pxl), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .busy(busy),
    .err_skew(err_skew), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] frame [NCH][MAP_N];
  logic [8:0] got   [TOTAL];

  typedef struct {
    logic [8:0] din;
    logic [8:0] dexp;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [8:0] stored(input logic [8:0] v);
`ifdef POOL_FRAME_BUFFER_RELU_EN
    return v[8] ? 9'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_beat(input int i);
    pool_valid = '1;
    for (int c = 0; c < NCH; c++) pool_in[c*9 +: 9] = frame[c][i];
  endtask

  task automatic fill(input int skew_at);
    for (int i = 0; i < MAP_N; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        pool_valid = '0;
      end
      if (i == skew_at) begin
        @(negedge clk);
        pool_valid = 6'b000111;
        pool_in    = 54'({$urandom, $urandom});
      end
      @(negedge clk);
      chk("fill_out_valid_low", out_valid, 0);
      drive_beat(i);
    end
    @(negedge clk);
    pool_valid = '0;
    chk("drain_entry_busy", busy, 1);
    chk("drain_entry_out_valid", out_valid, 0);
  endtask

  task automatic drain(input bit rnd, input int hold_at, input bit ovr);
    int k = 0, cyc = 0, gaps = 0, hold = 0;
    bit stalled = 0, injected = 0, r;
    logic [8:0] hp;
    logic [2:0] hc;
    while (k < TOTAL && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      pool_valid = '0;
      if (ovr && !injected && k == 300) begin
        pool_valid = '1;
        pool_in    = 54'({$urandom, $urandom});
        injected   = 1;
      end
      chk("frame_done_early", frame_done, 0);
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_ch, out_pxl}, {hc, hp});
      end
      if (hold_at >= 0 && k == hold_at && hold < 10) begin
        r = 0;
        hold++;
      end else begin
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = r;
      if (out_valid) begin
        if (r) begin
          got[k] = out_pxl;
          chk("replay", {out_ch, out_pxl},
              {3'(k / MAP_N), stored(frame[k / MAP_N][k % MAP_N])});
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          hp = out_pxl;
          hc = out_ch;
        end
      end else begin
        gaps++;
        stalled = 0;
      end
    end
    if (k < TOTAL) chk("drain_timeout", k, TOTAL);
    @(negedge clk);
    out_ready = 1'($urandom_range(0, 1));
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_falls", busy, 0);
    chk("out_valid_falls", out_valid, 0);
    @(negedge clk);
    chk("frame_done_single", frame_done, 0);
    chk("out_valid_idle", out_valid, 0);
    if (!rnd) chk("no_gaps", gaps, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{9'h100, stored(9'h100)};
    tbl[1] = '{9'h0FF, 9'h0FF};
`ifdef POOL_FRAME_BUFFER_RELU_EN
    tbl[0].dexp = 9'h000;
    tbl[2] = '{9'h1FF, 9'h000};
    tbl[5] = '{9'h180, 9'h000};
`else
    tbl[0].dexp = 9'h100;
    tbl[2] = '{9'h1FF, 9'h1FF};
    tbl[5] = '{9'h180, 9'h180};
`endif
    tbl[3] = '{9'h000, 9'h000};
    tbl[4] = '{9'h001, 9'h001};

    reset = 1'b0; pool_in = '0; pool_valid = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pxl", out_pxl, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_skew", err_skew, 0);
    chk("rst_err_overrun", err_overrun, 0);
    reset = 1'b1;
    @(negedge clk);

    // partial frame discarded by reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      pool_valid = '1;
      pool_in = 54'({$urandom, $urandom});
    end
    @(negedge clk);
    pool_valid = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", busy, 0);
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < MAP_N; i++) frame[c][i] = 9'(c * 16 + i % 16);
    fill(-1);
    drain(0, -1, 0);
    chk("midrst_err_skew", err_skew, 0);
    chk("midrst_err_overrun", err_overrun, 0);

    // full frame, always ready
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < MAP_N; i++) frame[c][i] = 9'(c * MAP_N + i);
    fill(-1);
    drain(0, -1, 0);

    // same frame with random backpressure and a long hold at the ch0/ch1 boundary
    fill(-1);
    drain(1, MAP_N, 0);
    chk("bp_err_overrun", err_overrun, 0);

    // signed values on channel 2, with an overrun beat during replay
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < MAP_N; i++)
        frame[c][i] = (c == 2) ? tbl[i % 6].din : 9'($urandom);
    fill(-1);
    drain(1, -1, 1);
    for (int i = 0; i < MAP_N; i++)
      chk("signed_table", got[2 * MAP_N + i], tbl[i % 6].dexp);
    chk("ovr_err_overrun", err_overrun, 1);
    chk("ovr_err_skew", err_skew, 0);

    // skewed valid cycle mid-capture
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < MAP_N; i++) frame[c][i] = 9'($urandom);
    fill(100);
    chk("skew_set", err_skew, 1);
    drain(0, -1, 0);
    chk("skew_sticky", err_skew, 1);
    chk("overrun_sticky", err_overrun, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_frame_buffer.md
Name: pool_frame_buffer

Overview:
- Downstream stage of the six parallel layer-1 conv+pool channels.
- Captures the six 14x14 pooled feature maps of one 32x32 input frame as they stream out in parallel, one word per channel per valid beat.
- Once a full frame is captured, replays it channel-major (ch0 raster, then ch1, ... ch5) over a valid/ready handshake to the layer-2 convolution front end.
- Single buffer: capture and replay alternate, they never overlap.

Parameters:
- OP, 8, MSB index of pooled pixel (word is signed [OP:0], 9 bits).
- NCH, 6, number of input channels.
- MAP_W, 14, pooled map width.
- MAP_H, 14, pooled map height.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pool_in  in  NCH*(OP+1)  packed pooled pixels; channel c at bits [c*(OP+1) +: OP+1], signed.
- pool_valid  in  NCH  per-channel valid from each layer-1 instance.
- out_pxl  out  OP+1  signed replayed pixel.
- out_ch  out  3  channel index of out_pxl.
- out_valid  out  1  out_pxl/out_ch valid.
- out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
- frame_done  out  1  one-cycle pulse after the last replayed beat is accepted.
- busy  out  1  high in DRAIN.
- err_skew  out  1  sticky: pool_valid bits disagreed in some cycle.
- err_overrun  out  1  sticky: input beat arrived while not in FILL.

Behaviour:
- Storage: NCH*MAP_W*MAP_H words (1176 x 9 bits), address = ch*196 + row*14 + col. Inferred RAM: synchronous write, registered read (1-cycle read latency).
- Reset (reset==0, async): state=FILL, write count=0, read address=0, out_valid=0, out_pxl=0, out_ch=0, frame_done=0, busy=0, err_skew=0, err_overrun=0. RAM contents undefined. A reset mid-FILL or mid-DRAIN discards the partial frame.
- Beat definition: a cycle with pool_valid == all-ones.
- Skew: a cycle where pool_valid is neither all-zeros nor all-ones sets err_skew. That cycle writes nothing and does not advance the count.
- FILL:
  - Each beat writes all NCH words at the same pixel index wcnt (0..195), then wcnt++.
  - The beat at wcnt==195 writes, clears wcnt to 0 and moves to DRAIN next cycle.
- DRAIN:
  - busy=1.
  - Reads addresses 0..1175 in order through a 2-entry output skid, so out_valid can stay high every cycle while out_ready=1 (throughput 1 beat/clk after 1-cycle initial latency).
  - First out_valid occurs 1 cycle after entering DRAIN.
  - While out_valid && !out_ready: out_pxl and out_ch hold stable. No beat is dropped or duplicated.
  - out_ch = address / 196, registered alongside the data.
  - On acceptance of address 1175: frame_done=1 for exactly one cycle, out_valid falls the next cycle, state returns to FILL and busy falls in the same cycle as frame_done.
- Overrun: any beat in DRAIN sets err_overrun and the data is dropped. The pool stage has no backpressure, and the system guarantees drain completes in the inter-frame gap.
- Arithmetic: none beyond counters. Pixels are stored bit-exact (or per RELU_EN). Counters wrap only by explicit reset-to-0 at the limits above.

Optional Feature:
- Macro: POOL_FRAME_BUFFER_RELU_EN.
- Defined: each word is clamped on write; negative values (MSB=1) are stored as 0, non-negative values unchanged. This applies the layer-1 activation in this block.
- Undefined: words are stored and replayed exactly as received, with sign preserved.
- Control timing is identical in both builds.

Test Plan:
- Reset mid-frame: drive 50 beats, pull reset low 3 cycles, drive 196 beats with value = ch*16 + (idx mod 16) -> out_valid=0 until DRAIN; replay starts with ch0 idx0 = 0, no stale data; errors 0.
- Full frame, out_ready=1 constantly: 196 beats of pixel = ch*196 + idx (truncated to 9 bits, signed) -> 1176 consecutive out_valid beats in address order; out_ch steps 0..5 every 196 beats; frame_done pulses once on beat 1176.
- Backpressure: out_ready random 50%, plus a 10-cycle hold at beat 195/196 (channel boundary) -> out_pxl/out_ch stable while stalled; sequence identical to the previous case; no loss or duplicate.
- Skew: pool_valid=6'b000111 for one cycle mid-FILL -> err_skew=1 (sticky), wcnt unchanged; frame still completes after 196 proper beats.
- Overrun: assert pool_valid=6'h3F during DRAIN -> err_overrun=1, replayed data unchanged.
- Signed values: channel 2 fed -256 and +255 alternately -> without RELU_EN replays 9'h100/9'h0FF; with POOL_FRAME_BUFFER_RELU_EN replays 0/9'h0FF.
